// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the valid/ready link into decode.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  id_sign_func;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_sign_func,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_sign_func,
    output id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem requests, buffers returned
// words with their PC and immediate-format pre-decode, and feeds decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   pc, resp_pc, redirect_target;
  logic [CW-1:0] outstanding, drop, fifo_count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [2:0]    fifo_sf    [FIFO_DEPTH];
  logic [31:0]   hold_instr, hold_pc;
  logic [2:0]    hold_sf;
  logic [CW:0]   occupancy;
  logic          issue, grant, push, pop, head_valid;

  function automatic logic [2:0] sign_func(input logic [6:0] opcode, input logic [2:0] funct3);
    logic [2:0] sf;
    sf = 3'b000;
    case (opcode)
      7'b0100011:             sf = 3'b111;
      7'b0110111, 7'b0010111: sf = 3'b001;
      7'b1101111:             sf = 3'b010;
      7'b1100011:             sf = 3'b011;
      7'b0010011:             if (funct3 == 3'b001 || funct3 == 3'b101) sf = 3'b100;
      default:                sf = 3'b000;
    endcase
    return sf;
  endfunction

  // Issue is capped so every granted word is guaranteed a FIFO slot on return.
  always_comb begin
    occupancy       = {1'b0, outstanding} + {1'b0, fifo_count};
    head_valid      = (fifo_count != '0);
    issue           = rst_n && !bus.redirect_valid && (occupancy < DEPTH_C);
    grant           = issue && bus.imem_gnt;
    push            = bus.imem_rvalid && !bus.redirect_valid && (drop == '0);
    pop             = head_valid && bus.id_ready && !bus.redirect_valid;
    redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      hold_instr  <= NOP;
      hold_pc     <= '0;
      hold_sf     <= 3'b000;
    end else begin
      if (head_valid) begin
        hold_instr <= fifo_instr[rd_ptr];
        hold_pc    <= fifo_pc[rd_ptr];
        hold_sf    <= fifo_sf[rd_ptr];
      end
      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        pc          <= redirect_target;
        resp_pc     <= redirect_target;
        fifo_count  <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= outstanding - CW'(bus.imem_rvalid);
        drop        <= outstanding - CW'(bus.imem_rvalid);
      end else begin
        if (grant) pc <= pc + 32'd4;
        outstanding <= outstanding + CW'(grant) - CW'(bus.imem_rvalid);
        if (bus.imem_rvalid && drop != '0) drop <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_sf[wr_ptr]    <= sign_func(bus.imem_rdata[6:0], bus.imem_rdata[14:12]);
    end
  end

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = pc & 32'hFFFF_FFFC;
  assign bus.id_valid     = head_valid;
  assign bus.id_instr     = head_valid ? fifo_instr[rd_ptr] : hold_instr;
  assign bus.id_pc        = head_valid ? fifo_pc[rd_ptr]    : hold_pc;
  assign bus.id_sign_func = head_valid ? fifo_sf[rd_ptr]    : hold_sf;
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: in-order memory model with variable latency and a
// scoreboard of expected {instr, pc, sign_func} pushed at grant, popped at transfer.
module tb_fetch_stage;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] prog_instr [8] = '{32'h00A00093, 32'h00112023, 32'h000012B7, 32'h008000EF,
                                  32'h00208463, 32'h00509093, 32'h00000297, 32'h40515093};
  logic [2:0]  prog_sf    [8] = '{3'b000, 3'b111, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001, 3'b100};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          drop_model = 0;
  int          first_grant_cyc = -1;
  bit          lat_armed  = 1'b1;
  bit          flush_prev = 1'b0;
  logic [31:0] model_pc = RESET_PC;
  exp_t        last_shown = '{instr: 32'h0000_0013, pc: 32'h0, sf: 3'b000};
  exp_t        sb [$];
  logic [31:0] addr_q [$];
  int          due_q [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instrAt(input logic [31:0] addr);
    logic [31:0] base;
    base = prog_instr[addr[4:2]];
    if (addr < 32'd32) return base;
    return {addr[13:2], base[19:0]};
  endfunction

  function automatic exp_t expectAt(input logic [31:0] addr);
    exp_t e;
    e.instr = instrAt(addr);
    e.pc    = addr;
    e.sf    = prog_sf[addr[4:2]];
    return e;
  endfunction

  // Memory: answers each grant in order after 'lat' cycles.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        addr_q.delete();
        due_q.delete();
        bus.imem_rvalid = 1'b0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instrAt(addr_q[0]);
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
    end
  end

  // Monitor on the falling edge: checks outputs, then advances the model for the coming edge.
  initial begin
    int occ;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        addr_q.delete();
        due_q.delete();
        drop_model      = 0;
        model_pc        = RESET_PC;
        last_shown      = '{instr: 32'h0000_0013, pc: 32'h0, sf: 3'b000};
        flush_prev      = 1'b0;
        lat_armed       = 1'b1;
        first_grant_cyc = -1;
      end else begin
        occ = sb.size() + drop_model;
        checkOutput("occupancy_cap", 32'(occ <= DEPTH), 32'd1);
        checkOutput("imem_req", 32'(bus.imem_req), 32'(!bus.redirect_valid && occ < DEPTH));
        if (bus.imem_req) checkOutput("imem_addr", bus.imem_addr, model_pc);
        if (flush_prev) checkOutput("flush_id_valid", 32'(bus.id_valid), 32'd0);
        if (bus.id_valid) begin
          checkOutput("head_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            checkOutput("id_instr", bus.id_instr, sb[0].instr);
            checkOutput("id_pc", bus.id_pc, sb[0].pc);
            checkOutput("id_sign_func", 32'(bus.id_sign_func), 32'(sb[0].sf));
            last_shown = sb[0];
          end
          if (lat_armed && first_grant_cyc >= 0) begin
            checkOutput("first_valid_latency", 32'(cyc - first_grant_cyc), 32'd2);
            lat_armed = 1'b0;
          end
        end else begin
          checkOutput("hold_instr", bus.id_instr, last_shown.instr);
          checkOutput("hold_pc", bus.id_pc, last_shown.pc);
          checkOutput("hold_sign_func", 32'(bus.id_sign_func), 32'(last_shown.sf));
        end
        flush_prev = 1'b0;
        if (bus.imem_req && bus.imem_gnt) begin
          addr_q.push_back(bus.imem_addr);
          due_q.push_back(cyc + lat);
        end
        if (bus.redirect_valid) begin
          sb.delete();
          drop_model = addr_q.size();
          model_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
          flush_prev = 1'b1;
        end else begin
          if (bus.imem_rvalid && drop_model > 0) drop_model--;
          if (bus.id_valid && bus.id_ready && sb.size() > 0) void'(sb.pop_front());
          if (bus.imem_req && bus.imem_gnt) begin
            sb.push_back(expectAt(model_pc));
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
            model_pc = model_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic gnt, input logic ready, input int cycles);
    bus.imem_gnt = gnt;
    bus.id_ready = ready;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseRedirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int limit);
    int i;
    for (i = 0; i < limit && !bus.id_valid; i++) begin
      @(posedge clk);
      #1;
    end
    if (!bus.id_valid) checkOutput(tag, 32'(bus.id_valid), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
    checkOutput({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
    checkOutput({tag, "_id_instr"}, bus.id_instr, 32'h0000_0013);
    checkOutput({tag, "_id_pc"}, bus.id_pc, 32'h0);
    checkOutput({tag, "_id_sign_func"}, 32'(bus.id_sign_func), 32'd0);
  endtask

  initial begin
    bus.imem_gnt       = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");

    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Free run from RESET_PC covering the sign_func program table.
    applyStimulus(1'b1, 1'b1, 30);

    // Decode stall: issue must stop at the cap with the head held.
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("stall_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("stall_id_valid", 32'(bus.id_valid), 32'd1);
    applyStimulus(1'b1, 1'b1, 10);

    // Redirect with words in flight on a 2-cycle memory.
    lat = 2;
    bus.id_ready = 1'b0;
    pulseRedirect(32'h0000_0040);
    applyStimulus(1'b1, 1'b0, 2);
    pulseRedirect(32'h0000_0103);
    waitValid("redirect_a_timeout", 20);
    checkOutput("redirect_a_pc", bus.id_pc, 32'h0000_0100);
    applyStimulus(1'b1, 1'b1, 10);

    // Redirect while the FIFO is full and stalled.
    applyStimulus(1'b1, 1'b0, 8);
    pulseRedirect(32'h0000_0080);
    waitValid("redirect_b_timeout", 20);
    checkOutput("redirect_b_pc", bus.id_pc, 32'h0000_0080);
    applyStimulus(1'b1, 1'b1, 10);

    // Grant withheld, then PC wrap at the top of the address space.
    lat = 1;
    applyStimulus(1'b0, 1'b1, 6);
    pulseRedirect(32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("no_gnt_addr", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("wrap_addr", bus.imem_addr, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1, 8);

    // Asynchronous reset in the middle of a stall.
    applyStimulus(1'b1, 1'b0, 4);
    #2 rst_n = 1'b0;
    bus.imem_gnt = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1);
    waitValid("restart_timeout", 10);
    checkOutput("restart_pc", bus.id_pc, RESET_PC);
    applyStimulus(1'b1, 1'b1, 10);

    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("drain_scoreboard", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
